// File: rtl/gpu2d_bg_tile_row_reader_if.sv
// ---------------------------------------------------------------------------
// gpu2d_bg_tile_row_reader_if
//   Bundles every signal of the BG tile-row reader except clock and reset:
//   request handshake (line fetcher side), RAM read port, pixel stream
//   (palette lookup side) and the busy flag.
//   Modports:
//     slave  - the row reader itself
//     master - its environment (requester, RAM, pixel consumer)
//   Signals:
//     io_req_valid/ready/addr/xFlip  tile-row request handshake
//     io_rdEn/io_rdAddr/io_rdData    RAM read port (1-cycle registered read)
//     io_pix_valid/ready/colIdx/idx/last  pixel stream
//     io_busy                        reader not idle
// ---------------------------------------------------------------------------
interface gpu2d_bg_tile_row_reader_if #(
  parameter int ADDR_WIDTH    = 12,
  parameter int COL_IDX_WIDTH = 6,
  parameter int ROW_PIXELS    = 16
);
  localparam int ROW_W = ROW_PIXELS * COL_IDX_WIDTH;
  localparam int IDX_W = $clog2(ROW_PIXELS);

  logic                     io_req_valid;
  logic                     io_req_ready;
  logic [ADDR_WIDTH-1:0]    io_req_addr;
  logic                     io_req_xFlip;

  logic                     io_rdEn;
  logic [ADDR_WIDTH-1:0]    io_rdAddr;
  logic [ROW_W-1:0]         io_rdData;

  logic                     io_pix_valid;
  logic                     io_pix_ready;
  logic [COL_IDX_WIDTH-1:0] io_pix_colIdx;
  logic [IDX_W-1:0]         io_pix_idx;
  logic                     io_pix_last;

  logic                     io_busy;

  modport slave (
    input  io_req_valid, io_req_addr, io_req_xFlip, io_rdData, io_pix_ready,
    output io_req_ready, io_rdEn, io_rdAddr,
    output io_pix_valid, io_pix_colIdx, io_pix_idx, io_pix_last, io_busy
  );

  modport master (
    output io_req_valid, io_req_addr, io_req_xFlip, io_rdData, io_pix_ready,
    input  io_req_ready, io_rdEn, io_rdAddr,
    input  io_pix_valid, io_pix_colIdx, io_pix_idx, io_pix_last, io_busy
  );
endinterface

// File: rtl/gpu2d_bg_tile_row_reader.sv
// ---------------------------------------------------------------------------
// gpu2d_bg_tile_row_reader
//   Accepts one tile-row request, reads that row from the BG tile RAM
//   (1-cycle registered read), captures the packed ROW_PIXELS x colIdx row
//   and streams it out pixel by pixel with valid/ready backpressure,
//   optionally in reverse element order (horizontal flip).
//   Ports:
//     clk    clock, everything on posedge
//     reset  synchronous, active-high
//     bus    gpu2d_bg_tile_row_reader_if.slave (request, RAM read, pixels)
//   Sequence: IDLE (accept, RAM read issued) -> WAIT (capture row)
//             -> EMIT (ROW_PIXELS handshakes) -> IDLE.
// ---------------------------------------------------------------------------
module gpu2d_bg_tile_row_reader #(
  parameter int ADDR_WIDTH    = 12,
  parameter int COL_IDX_WIDTH = 6,
  parameter int ROW_PIXELS    = 16
) (
  input  logic clk,
  input  logic reset,
  gpu2d_bg_tile_row_reader_if.slave bus
);

  localparam int ROW_W = ROW_PIXELS * COL_IDX_WIDTH;
  localparam int CTR_W = $clog2(ROW_PIXELS);
  localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(ROW_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  state_e                state_q,   state_d;
  logic [CTR_W-1:0]      ctr_q,     ctr_d;
  logic [ROW_W-1:0]      buf_q,     buf_d;
  logic                  flip_q,    flip_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic             req_ready;
  logic             accept;
  logic             pix_valid;
  logic             pix_last;
  logic             pix_fire;
  logic [CTR_W-1:0] elem;

  // Handshake qualifiers are gated by reset so nothing is offered or
  // accepted in the cycle reset is being applied.
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = bus.io_req_valid && req_ready;
  assign pix_valid = (state_q == S_EMIT) && !reset;
  assign pix_last  = (ctr_q == LAST_IDX);
  assign pix_fire  = pix_valid && bus.io_pix_ready;

  // Flip maps screen position ctr to element ROW_PIXELS-1-ctr.
  assign elem = flip_q ? (LAST_IDX - ctr_q) : ctr_q;

  // The RAM address is driven in the accept cycle itself so the registered
  // read returns data in WAIT; otherwise it holds the last accepted row.
  assign bus.io_req_ready  = req_ready;
  assign bus.io_rdEn       = accept;
  assign bus.io_rdAddr     = accept ? bus.io_req_addr : rd_addr_q;
  assign bus.io_pix_valid  = pix_valid;
  assign bus.io_pix_colIdx = pix_valid ? buf_q[elem*COL_IDX_WIDTH +: COL_IDX_WIDTH] : '0;
  assign bus.io_pix_idx    = pix_valid ? ctr_q : '0;
  assign bus.io_pix_last   = pix_valid && pix_last;
  assign bus.io_busy       = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    ctr_d     = ctr_q;
    buf_d     = buf_q;
    flip_d    = flip_q;
    rd_addr_d = rd_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          flip_d    = bus.io_req_xFlip;
          rd_addr_d = bus.io_req_addr;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Whatever the RAM shows now is the row; no retry.
        buf_d   = bus.io_rdData;
        ctr_d   = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (pix_fire) begin
          if (pix_last) begin
            ctr_d   = '0;
            state_d = S_IDLE;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: buf_q is a plain register row, not a RAM macro, so clearing it
      // on reset is cheap and keeps a discarded row from leaking out.
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      buf_q     <= '0;
      flip_q    <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed before this edge, independent of statement order.
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      buf_q     <= buf_d;
      flip_q    <= flip_d;
      rd_addr_q <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_gpu2d_bg_tile_row_reader.sv
// ---------------------------------------------------------------------------
// tb_gpu2d_bg_tile_row_reader
//   Directed bench for gpu2d_bg_tile_row_reader with a behavioural
//   1-cycle registered-read RAM. Inputs change on negedge; outputs are
//   sampled 1 time unit later, away from the active posedge.
// ---------------------------------------------------------------------------
module tb_gpu2d_bg_tile_row_reader;

  localparam int AW = 12;
  localparam int CW = 6;
  localparam int RP = 16;

  logic clk = 1'b0;
  logic reset;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpu2d_bg_tile_row_reader_if #(.ADDR_WIDTH(AW), .COL_IDX_WIDTH(CW), .ROW_PIXELS(RP)) bus ();

  gpu2d_bg_tile_row_reader #(.ADDR_WIDTH(AW), .COL_IDX_WIDTH(CW), .ROW_PIXELS(RP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [RP*CW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.io_rdEn) bus.io_rdData <= mem[bus.io_rdAddr];
  end

  // Element i of a generated row is (base + stp*i) mod 64.
  function automatic logic [CW-1:0] gen_elem(input int base, input int stp, input int i);
    return CW'((base + stp * i) & 63);
  endfunction

  task automatic fill_row(input int addr, input int base, input int stp);
    logic [RP*CW-1:0] r;
    r = '0;
    for (int i = 0; i < RP; i++) r[i*CW +: CW] = gen_elem(base, stp, i);
    mem[addr] = r;
  endtask

  // {valid, colIdx, idx, last}
  function automatic logic [11:0] pix_tuple();
    return {bus.io_pix_valid, bus.io_pix_colIdx, bus.io_pix_idx, bus.io_pix_last};
  endfunction

  task automatic test_reset();
    logic [2:0]  got3;
    logic [26:0] got, exp;
    reset = 1'b1;
    bus.io_req_valid = 1'b1;
    bus.io_req_addr  = 12'h123;
    bus.io_req_xFlip = 1'b0;
    bus.io_pix_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    got3 = {bus.io_req_ready, bus.io_rdEn, bus.io_pix_valid};
    vectors++;
    if (got3 !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_hold: {req_ready,rdEn,pix_valid} got %b want 000", got3);
    end
    bus.io_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    got = {bus.io_req_ready, bus.io_rdEn, bus.io_rdAddr, bus.io_pix_valid,
           bus.io_pix_colIdx, bus.io_pix_idx, bus.io_pix_last, bus.io_busy};
    exp = {1'b1, 1'b0, 12'h000, 1'b0, 6'h00, 4'h0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL post_reset_outputs: got %h want %h", got, exp);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      got3 = {bus.io_req_ready, bus.io_rdEn, bus.io_busy};
      vectors++;
      if (got3 !== 3'b100) begin
        miscompares++;
        $display("FAIL idle_no_rden cyc %0d: {req_ready,rdEn,busy} got %b want 100", c, got3);
      end
    end
    @(negedge clk);
  endtask

  // One full row at pix_ready=1. Entry and exit: at a negedge.
  task automatic test_row(input string nm, input int addr, input bit flip,
                          input int base, input int stp);
    logic [13:0] got14, exp14;
    logic [11:0] got, exp;
    logic [2:0]  got3;
    int          pulses;
    int          e;
    bus.io_req_valid = 1'b1;
    bus.io_req_addr  = AW'(addr);
    bus.io_req_xFlip = flip;
    bus.io_pix_ready = 1'b1;
    #1;
    got14 = {bus.io_rdEn, bus.io_req_ready, bus.io_rdAddr};
    exp14 = {1'b1, 1'b1, AW'(addr)};
    vectors++;
    if (got14 !== exp14) begin
      miscompares++;
      $display("FAIL %s accept: {rdEn,req_ready,rdAddr} got %h want %h", nm, got14, exp14);
    end
    pulses = 1;
    @(negedge clk);
    bus.io_req_valid = 1'b0;
    #1;
    got14 = {bus.io_pix_valid, bus.io_busy, bus.io_rdEn, bus.io_req_ready, bus.io_rdAddr} >> 0;
    exp14 = {1'b0, 1'b1, 1'b0, 1'b0, AW'(addr)} >> 0;
    vectors++;
    if ({bus.io_pix_valid, bus.io_busy, bus.io_rdEn, bus.io_req_ready, bus.io_rdAddr}
        !== {1'b0, 1'b1, 1'b0, 1'b0, AW'(addr)}) begin
      miscompares++;
      $display("FAIL %s wait_state: {pv,busy,rdEn,rr,rdAddr} got %b_%b_%b_%b_%h want 0_1_0_0_%h",
               nm, bus.io_pix_valid, bus.io_busy, bus.io_rdEn, bus.io_req_ready,
               bus.io_rdAddr, AW'(addr));
    end
    for (int p = 0; p < RP; p++) begin
      @(negedge clk);
      #1;
      if (bus.io_rdEn) pulses++;
      e   = flip ? (RP - 1 - p) : p;
      got = pix_tuple();
      exp = {1'b1, gen_elem(base, stp, e), 4'(p), (p == RP - 1)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s pixel %0d: {v,col,idx,last} got %h want %h", nm, p, got, exp);
      end
    end
    @(negedge clk);
    #1;
    if (bus.io_rdEn) pulses++;
    got3 = {bus.io_req_ready, bus.io_busy, bus.io_pix_valid};
    vectors++;
    if (got3 !== 3'b100) begin
      miscompares++;
      $display("FAIL %s back_to_idle: {req_ready,busy,pix_valid} got %b want 100", nm, got3);
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL %s rden_pulses: got %0d want 1", nm, pulses);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [11:0] got, exp;
    int cnt = 0;
    int hs  = 0;
    int cyc = 0;
    fill_row(12'hFFF, 63, 0);
    bus.io_req_valid = 1'b1;
    bus.io_req_addr  = 12'hFFF;
    bus.io_req_xFlip = 1'b0;
    bus.io_pix_ready = 1'b0;
    #1;
    vectors++;
    if ({bus.io_rdEn, bus.io_rdAddr} !== {1'b1, 12'hFFF}) begin
      miscompares++;
      $display("FAIL bp_accept: {rdEn,rdAddr} got %b_%h want 1_fff", bus.io_rdEn, bus.io_rdAddr);
    end
    @(negedge clk);
    bus.io_req_valid = 1'b1;  // held high to show it is ignored while busy
    while (cnt < RP && cyc < 100) begin
      @(negedge clk);
      bus.io_pix_ready = (cyc % 3 == 0);
      #1;
      got = pix_tuple();
      exp = {1'b1, 6'h3F, 4'(cnt), (cnt == RP - 1)};
      vectors++;
      if (got !== exp || bus.io_req_ready !== 1'b0 || bus.io_rdEn !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_pixel cyc %0d: {v,col,idx,last} got %h want %h, req_ready %b rdEn %b want 0 0",
                 cyc, got, exp, bus.io_req_ready, bus.io_rdEn);
      end
      if (bus.io_pix_valid && bus.io_pix_ready) hs++;
      if (bus.io_pix_ready) cnt++;
      cyc++;
    end
    vectors++;
    if (hs !== RP) begin
      miscompares++;
      $display("FAIL bp_handshakes: got %0d want %0d", hs, RP);
    end
    bus.io_req_valid = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.io_req_ready, bus.io_pix_valid, bus.io_busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL bp_idle_after_last: {req_ready,pix_valid,busy} got %b want 100",
               {bus.io_req_ready, bus.io_pix_valid, bus.io_busy});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp;
    int t_first  = -1;
    int t_second = -1;
    int n_pulses = 0;
    logic [AW-1:0] addr_second = '0;
    fill_row(12'h001, 16, 1);
    fill_row(12'h002, 48, 2);
    bus.io_req_valid = 1'b1;
    bus.io_req_addr  = 12'h001;
    bus.io_req_xFlip = 1'b0;
    bus.io_pix_ready = 1'b1;
    for (int t = 0; t < 38; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 1)  bus.io_req_addr  = 12'h002;
      if (t == 19) bus.io_req_valid = 1'b0;
      #1;
      if (bus.io_rdEn) begin
        n_pulses++;
        if (n_pulses == 1) t_first = t;
        if (n_pulses == 2) begin
          t_second    = t;
          addr_second = bus.io_rdAddr;
        end
      end
      if ((t >= 2 && t <= 17) || (t >= 20 && t <= 35)) begin
        got = pix_tuple();
        if (t <= 17) exp = {1'b1, gen_elem(16, 1, t - 2),  4'(t - 2),  (t == 17)};
        else         exp = {1'b1, gen_elem(48, 2, t - 20), 4'(t - 20), (t == 35)};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL b2b pixel t=%0d: {v,col,idx,last} got %h want %h", t, got, exp);
        end
      end
    end
    vectors++;
    if (n_pulses !== 2 || t_first !== 0 || t_second !== 18 || addr_second !== 12'h002) begin
      miscompares++;
      $display("FAIL b2b_spacing: pulses %0d at t=%0d,%0d addr2 %h want 2 at t=0,18 addr2 002",
               n_pulses, t_first, t_second, addr_second);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_emit();
    logic [11:0] got, exp;
    logic [2:0]  got3;
    fill_row(12'h005, 1, 1);
    bus.io_req_valid = 1'b1;
    bus.io_req_addr  = 12'h005;
    bus.io_req_xFlip = 1'b0;
    bus.io_pix_ready = 1'b1;
    @(negedge clk);
    bus.io_req_valid = 1'b0;
    for (int p = 0; p < 8; p++) @(negedge clk);
    #1;
    got = pix_tuple();
    exp = {1'b1, 6'd8, 4'd7, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL rst_mid at_pixel7: {v,col,idx,last} got %h want %h", got, exp);
    end
    reset = 1'b1;
    #1;
    got3 = {bus.io_pix_valid, bus.io_req_ready, bus.io_rdEn};
    vectors++;
    if (got3 !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid during_reset: {pix_valid,req_ready,rdEn} got %b want 000", got3);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    got3 = {bus.io_pix_valid, bus.io_busy, bus.io_req_ready};
    vectors++;
    if (got3 !== 3'b001) begin
      miscompares++;
      $display("FAIL rst_mid after_reset: {pix_valid,busy,req_ready} got %b want 001", got3);
    end
    @(negedge clk);
    test_row("restart", 12'h005, 1'b0, 1, 1);
  endtask

  initial begin
    reset            = 1'b1;
    bus.io_req_valid = 1'b0;
    bus.io_req_addr  = '0;
    bus.io_req_xFlip = 1'b0;
    bus.io_pix_ready = 1'b0;
    fill_row(12'h005, 1, 1);
    test_reset();
    test_row("row5_noflip", 12'h005, 1'b0, 1, 1);
    test_row("row5_flip",   12'h005, 1'b1, 1, 1);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
